// File: rtl/pwm_acc_pkg.sv
// pwm_acc_pkg: shared definitions for the pointwise-multiply accumulator.
//   state_t   : job FSM states
//   Q_DEFAULT : default modulus
//   lat_of    : accept-to-result latency for a given basemul depth
//   zeta_of   : basemul twiddle for pair k, 17^(2*bitrev(k)+1) mod q
package pwm_acc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int Q_DEFAULT = 3329;
    localparam int ZETA_G    = 17;

    // ROM read (1) + basemul (bm_lat) + accumulate/output register (1)
    function automatic int lat_of(input int bm_lat);
        return bm_lat + 2;
    endfunction

    function automatic int bitrev(input int v, input int bits);
        int res;
        res = 0;
        for (int i = 0; i < bits; i++) res = (res << 1) | ((v >> i) & 1);
        return res;
    endfunction

    function automatic int zeta_of(input int k, input int bits, input int q);
        longint z;
        int     e;
        z = 1;
        e = 2 * bitrev(k, bits) + 1;
        for (int i = 0; i < e; i++) z = (z * ZETA_G) % q;
        return int'(z);
    endfunction

endpackage

// File: rtl/pwm_basemul.sv
// pwm_basemul: one degree-1 base multiplication mod Q, fixed BM_LAT latency.
//   a0,a1,b0,b1 : operands in [0, Q-1]
//   zeta        : twiddle for this pair
//   p0 = a0*b0 + a1*b1*zeta mod Q,  p1 = a0*b1 + a1*b0 mod Q
// Arithmetic is a single combinational cone followed by a delay line so that
// retiming can spread it over the BM_LAT registers.
module pwm_basemul #(
    parameter int CW     = 16,
    parameter int Q      = 3329,
    parameter int BM_LAT = 3
) (
    input  logic          clk,
    input  logic [CW-1:0] a0,
    input  logic [CW-1:0] a1,
    input  logic [CW-1:0] b0,
    input  logic [CW-1:0] b1,
    input  logic [CW-1:0] zeta,
    output logic [CW-1:0] p0,
    output logic [CW-1:0] p1
);

    localparam int PW = 2 * CW;

    if (BM_LAT < 1) begin : g_chk_lat
        $error("pwm_basemul: BM_LAT must be at least 1");
    end

    logic [PW-1:0]  m11;
    logic [CW-1:0]  r11;
    logic [PW:0]    s0, s1;
    logic [CW-1:0]  c0, c1;
    logic [BM_LAT-1:0][2*CW-1:0] dly;

    always_comb begin
        m11 = PW'(a1) * PW'(b1);
        r11 = CW'(m11 % PW'(Q));
        s0  = (PW+1)'(PW'(a0) * PW'(b0)) + (PW+1)'(PW'(r11) * PW'(zeta));
        s1  = (PW+1)'(PW'(a0) * PW'(b1)) + (PW+1)'(PW'(a1) * PW'(b0));
        c0  = CW'(s0 % (PW+1)'(Q));
        c1  = CW'(s1 % (PW+1)'(Q));
    end

    always_ff @(posedge clk) begin
        dly[0] <= {c0, c1};
        for (int i = 1; i < BM_LAT; i++) dly[i] <= dly[i-1];
    end

    assign {p0, p1} = dly[BM_LAT-1];

endmodule

// File: rtl/pwm_zeta_rom.sv
// pwm_zeta_rom: constant twiddle table with LANES independent read ports.
//   clk  : clock
//   idx  : per-lane pair index
//   zeta : per-lane twiddle, registered (1-cycle latency)
module pwm_zeta_rom import pwm_acc_pkg::*; #(
    parameter int LANES   = 1,
    parameter int N_PAIRS = 128,
    parameter int CW      = 16,
    parameter int Q       = Q_DEFAULT,
    parameter int IW      = $clog2(N_PAIRS)
) (
    input  logic                      clk,
    input  logic [LANES-1:0][IW-1:0]  idx,
    output logic [LANES-1:0][CW-1:0]  zeta
);

    logic [CW-1:0] rom [N_PAIRS];

    for (genvar k = 0; k < N_PAIRS; k++) begin : g_rom
        assign rom[k] = CW'(zeta_of(k, IW, Q));
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) zeta[l] <= rom[idx[l]];
    end

endmodule

// File: rtl/pwm_acc.sv
// pwm_acc: streams nacc polynomial pairs through per-lane basemuls and
// accumulates the products mod Q in a BEATS-deep buffer; only the final pass
// produces output beats.
//   clk, srst        : clock, synchronous active-high reset
//   start, nacc      : job request, products to accumulate (0 -> 1)
//   in_valid/in_ready: input beat handshake, a/b = per lane {x0, x1}
//   out_valid, r     : result beat (no backpressure), per lane {r0, r1}
//   busy, done       : job in flight, one-cycle end-of-job pulse
module pwm_acc import pwm_acc_pkg::*; #(
    parameter int LANES   = 1,
    parameter int N_PAIRS = 128,
    parameter int CW      = 16,
    parameter int Q       = Q_DEFAULT,
    parameter int BM_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [3:0]            nacc,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*2*CW-1:0] a,
    input  logic [LANES*2*CW-1:0] b,
    output logic                  out_valid,
    output logic [LANES*2*CW-1:0] r,
    output logic                  busy,
    output logic                  done
);

    localparam int BEATS = N_PAIRS / LANES;
    localparam int LAT   = lat_of(BM_LAT);
    localparam int PS    = LAT - 1;            // stage where the product appears
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = $clog2(N_PAIRS);
    localparam int DW    = LANES * 2 * CW;

    if (N_PAIRS % LANES != 0) begin : g_chk_div
        $error("pwm_acc: N_PAIRS must be divisible by LANES");
    end
    if (BEATS <= LAT) begin : g_chk_rmw
        $error("pwm_acc: BEATS must exceed LAT to avoid buffer RMW hazards");
    end
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_chk_lanes
        $error("pwm_acc: LANES must be 1, 2 or 4");
    end

    state_t                state, state_nxt;
    logic [3:0]            nacc_q, pass_cnt;
    logic [BW-1:0]         beat_cnt;
    logic                  acc, beat_wrap, first_pass, last_pass;

    logic [LAT:1]          vld_pipe;
    logic [PS:1][BW-1:0]   idx_pipe;
    logic [PS:1]           first_pipe, last_pipe;

    logic [DW-1:0]         a_q, b_q, prod_flat, buf_rd, acc_sum;
    logic [LANES-1:0][IW-1:0]   zidx;
    logic [LANES-1:0][CW-1:0]   zeta;
    logic [LANES-1:0][2*CW-1:0] prod;
    logic [DW-1:0]         acc_buf [BEATS];
    logic [CW-1:0]         base;
    logic [CW:0]           sum;

    assign in_ready   = (state == RUN) && !srst;
    assign busy       = (state != IDLE) && !srst;
    assign acc        = in_valid && in_ready;
    assign beat_wrap  = (beat_cnt == BW'(BEATS - 1));
    assign first_pass = (pass_cnt == 4'd0);
    assign last_pass  = (pass_cnt == nacc_q - 4'd1);

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (acc && beat_wrap && last_pass) state_nxt = DRAIN;
            DRAIN:   if (~|vld_pipe) begin
                         done      = !srst;
                         state_nxt = IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            nacc_q   <= 4'd1;
            pass_cnt <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && start) begin
            nacc_q   <= (nacc == 4'd0) ? 4'd1 : nacc;
            pass_cnt <= '0;
            beat_cnt <= '0;
        end else if (acc) begin
            beat_cnt <= beat_wrap ? '0 : beat_cnt + 1'b1;
            if (beat_wrap) pass_cnt <= pass_cnt + 4'd1;
        end
    end

    // ---------------- pipeline ----------------
    // Zeta index comes from the accepted-beat counter, so input gaps never
    // skew it relative to the data.
    always_comb begin
        for (int l = 0; l < LANES; l++)
            zidx[l] = IW'(beat_cnt) * IW'(LANES) + IW'(l);
    end

    pwm_zeta_rom #(.LANES(LANES), .N_PAIRS(N_PAIRS), .CW(CW), .Q(Q), .IW(IW)) u_rom (
        .clk  (clk),
        .idx  (zidx),
        .zeta (zeta)
    );

    always_ff @(posedge clk) begin
        if (srst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[LAT-1:1], acc};
    end

    always_ff @(posedge clk) begin
        a_q           <= a;
        b_q           <= b;
        idx_pipe[1]   <= beat_cnt;
        first_pipe[1] <= first_pass;
        last_pipe[1]  <= last_pass;
        for (int s = 2; s <= PS; s++) begin
            idx_pipe[s]   <= idx_pipe[s-1];
            first_pipe[s] <= first_pipe[s-1];
            last_pipe[s]  <= last_pipe[s-1];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pwm_basemul #(.CW(CW), .Q(Q), .BM_LAT(BM_LAT)) u_bm (
            .clk  (clk),
            .a0   (a_q[l*2*CW+CW +: CW]),
            .a1   (a_q[l*2*CW    +: CW]),
            .b0   (b_q[l*2*CW+CW +: CW]),
            .b1   (b_q[l*2*CW    +: CW]),
            .zeta (zeta[l]),
            .p0   (prod[l][2*CW-1:CW]),
            .p1   (prod[l][CW-1:0])
        );
    end

    assign prod_flat = prod;
    assign buf_rd    = acc_buf[idx_pipe[PS]];

    // First pass adds to zero, so pass 1 and later passes share one adder;
    // both inputs are below Q, so one conditional subtract suffices.
    always_comb begin
        base    = '0;
        sum     = '0;
        acc_sum = '0;
        for (int j = 0; j < 2 * LANES; j++) begin
            base = first_pipe[PS] ? '0 : buf_rd[j*CW +: CW];
            sum  = {1'b0, base} + {1'b0, prod_flat[j*CW +: CW]};
            acc_sum[j*CW +: CW] = (sum >= (CW+1)'(Q)) ? CW'(sum - (CW+1)'(Q)) : sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[PS] && !last_pipe[PS]) acc_buf[idx_pipe[PS]] <= acc_sum;
        r <= acc_sum;
    end

    always_ff @(posedge clk) begin
        if (srst) out_valid <= 1'b0;
        else      out_valid <= vld_pipe[PS] && last_pipe[PS];
    end

endmodule

// File: tb/tb_pwm_acc.sv
module tb_pwm_acc;
    localparam int CW = 16, Q = 3329, NP = 128, BM_LAT = 3, LAT = BM_LAT + 2;

    logic clk = 1'b0;
    logic srst, start, in_valid, in_ready, out_valid, busy, done;
    logic [3:0]  nacc;
    logic [31:0] a, b, r;
    logic start4, in_valid4, in_ready4, out_valid4, busy4, done4;
    logic [3:0]   nacc4;
    logic [127:0] a4, b4, r4;

    always #5 clk = ~clk;

    pwm_acc #(.LANES(1), .N_PAIRS(NP), .CW(CW), .Q(Q), .BM_LAT(BM_LAT)) dut (
        .clk(clk), .srst(srst), .start(start), .nacc(nacc), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid), .r(r),
        .busy(busy), .done(done));

    pwm_acc #(.LANES(4), .N_PAIRS(NP), .CW(CW), .Q(Q), .BM_LAT(BM_LAT)) dut4 (
        .clk(clk), .srst(srst), .start(start4), .nacc(nacc4), .in_valid(in_valid4),
        .in_ready(in_ready4), .a(a4), .b(b4), .out_valid(out_valid4), .r(r4),
        .busy(busy4), .done(done4));

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int A0 [16][NP], A1 [16][NP], B0 [16][NP], B1 [16][NP];
    int zt [NP];
    int acc_q[$], out_cyc_q[$], done_q[$];
    logic [31:0]  out_r_q[$];
    logic [127:0] out4_q[$];
    int done4_n = 0, busy_low = 0;
    bit in_job = 0;

    // ---------------- reference model ----------------
    function automatic int modpow(input int g, input int e);
        longint x = 1;
        for (int i = 0; i < e; i++) x = (x * g) % Q;
        return int'(x);
    endfunction

    function automatic int brv7(input int v);
        int t = 0;
        for (int i = 0; i < 7; i++) if (v[i]) t |= 1 << (6 - i);
        return t;
    endfunction

    // Sum of the np pointwise products of pair k, reduced mod Q.
    function automatic logic [31:0] exp_pair(input int np, input int k);
        longint s0 = 0, s1 = 0;
        for (int j = 0; j < np; j++) begin
            s0 += longint'(A0[j][k]) * B0[j][k] + longint'(A1[j][k]) * B1[j][k] * zt[k];
            s1 += longint'(A0[j][k]) * B1[j][k] + longint'(A1[j][k]) * B0[j][k];
        end
        return {16'(s0 % Q), 16'(s1 % Q)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid) begin out_cyc_q.push_back(cyc); out_r_q.push_back(r); end
        if (done) done_q.push_back(cyc);
        if (in_job && !busy) busy_low++;
        if (out_valid4) out4_q.push_back(r4);
        if (done4) done4_n++;
    end

    task automatic fill(input int mode);
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < NP; k++)
                case (mode)
                    0: begin A0[j][k] = 1; A1[j][k] = 0; B0[j][k] = 5;    B1[j][k] = 7; end
                    1: begin A0[j][k] = 1; A1[j][k] = 0; B0[j][k] = 3328; B1[j][k] = 0; end
                    default: begin
                        A0[j][k] = $urandom_range(0, Q-1); A1[j][k] = $urandom_range(0, Q-1);
                        B0[j][k] = $urandom_range(0, Q-1); B1[j][k] = $urandom_range(0, Q-1);
                    end
                endcase
    endtask

    task automatic check_job(input string name, input int np);
        logic [31:0] e;
        n_cmp++;
        if (acc_q.size() !== np * NP) begin
            n_bad++; $display("FAIL %s accept_count got=%0d exp=%0d", name, acc_q.size(), np * NP);
        end
        n_cmp++;
        if (out_cyc_q.size() !== NP) begin
            n_bad++; $display("FAIL %s out_count got=%0d exp=%0d", name, out_cyc_q.size(), NP);
        end
        for (int i = 0; i < NP && i < out_cyc_q.size(); i++) begin
            if ((np - 1) * NP + i < acc_q.size()) begin
                n_cmp++;
                if (out_cyc_q[i] !== acc_q[(np-1)*NP + i] + LAT) begin
                    n_bad++;
                    $display("FAIL %s out_cycle[%0d] got=%0d exp=%0d", name, i, out_cyc_q[i], acc_q[(np-1)*NP + i] + LAT);
                end
            end
            e = exp_pair(np, i);
            n_cmp++;
            if (out_r_q[i] !== e) begin
                n_bad++; $display("FAIL %s r[%0d] got=%h exp=%h", name, i, out_r_q[i], e);
            end
        end
        n_cmp++;
        if (done_q.size() !== 1) begin
            n_bad++; $display("FAIL %s done_count got=%0d exp=1", name, done_q.size());
        end
        if (done_q.size() > 0 && out_cyc_q.size() > 0) begin
            n_cmp++;
            if (done_q[0] !== out_cyc_q[out_cyc_q.size()-1] + 1) begin
                n_bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_q[0], out_cyc_q[out_cyc_q.size()-1] + 1);
            end
        end
        n_cmp++;
        if (busy_low !== 0) begin
            n_bad++; $display("FAIL %s busy_low_cycles got=%0d exp=0", name, busy_low);
        end
    endtask

    // gap: 0 continuous, 1 toggling, 2 random. abort_at>0: srst after that many accepts.
    task automatic drive_job(input string name, input int n, input int gap, input int abort_at, input bit extra);
        int np, k, p, cnt, budget;
        bit tog, ac;
        np = (n == 0) ? 1 : n;
        k = 0; p = 0; cnt = 0; budget = 0; tog = 1'b1;
        acc_q.delete(); out_cyc_q.delete(); out_r_q.delete(); done_q.delete(); busy_low = 0;
        @(posedge clk); #1 start = 1'b1; nacc = 4'(n);
        @(posedge clk); #1 start = 1'b0; in_job = 1'b1;
        while (p < np && budget < 8000) begin
            case (gap)
                0: in_valid = 1'b1;
                1: begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            a = {16'(A0[p][k]), 16'(A1[p][k])};
            b = {16'(B0[p][k]), 16'(B1[p][k])};
            start = extra ? ($urandom_range(0, 2) == 0) : 1'b0;
            ac = in_valid && in_ready;
            @(posedge clk); #1;
            budget++;
            if (ac) begin
                cnt++; k++;
                if (k == NP) begin k = 0; p++; end
            end
            if (abort_at > 0 && cnt == abort_at) begin
                srst = 1'b1; in_valid = 1'b0; start = 1'b0;
                @(posedge clk); #1 srst = 1'b0;
                n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL %s in_ready_after_srst got=%b exp=0", name, in_ready); end
                n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL %s busy_after_srst got=%b exp=0", name, busy); end
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s out_valid_after_srst got=%b exp=0", name, out_valid); end
                in_job = 1'b0;
                repeat (LAT + 6) @(posedge clk);
                #1;
                n_cmp++; if (done_q.size() !== 0)    begin n_bad++; $display("FAIL %s done_after_abort got=%0d exp=0", name, done_q.size()); end
                n_cmp++; if (out_cyc_q.size() !== 0) begin n_bad++; $display("FAIL %s out_after_abort got=%0d exp=0", name, out_cyc_q.size()); end
                return;
            end
        end
        in_valid = 1'b0; start = 1'b0;
        n_cmp++;
        if (p !== np) begin n_bad++; $display("FAIL %s feed_timeout passes got=%0d exp=%0d", name, p, np); end
        budget = 0;
        while (done_q.size() == 0 && budget < LAT + 20) begin @(posedge clk); budget++; end
        in_job = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_job(name, np);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL reset in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset done got=%b exp=0", done); end
        n_cmp++; if (in_ready4 !== 1'b0)  begin n_bad++; $display("FAIL reset in_ready4 got=%b exp=0", in_ready4); end
        n_cmp++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL reset out_valid4 got=%b exp=0", out_valid4); end
        srst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lanes4(input int np);
        int p, i, budget;
        bit ac;
        logic [31:0] got, e;
        logic [127:0] beat;
        out4_q.delete(); done4_n = 0; p = 0; i = 0; budget = 0;
        @(posedge clk); #1 start4 = 1'b1; nacc4 = 4'(np);
        @(posedge clk); #1 start4 = 1'b0;
        while (p < np && budget < 4000) begin
            in_valid4 = 1'b1;
            for (int l = 0; l < 4; l++) begin
                a4[l*32 +: 32] = {16'(A0[p][4*i+l]), 16'(A1[p][4*i+l])};
                b4[l*32 +: 32] = {16'(B0[p][4*i+l]), 16'(B1[p][4*i+l])};
            end
            ac = in_ready4;
            @(posedge clk); #1;
            budget++;
            if (ac) begin i++; if (i == NP / 4) begin i = 0; p++; end end
        end
        in_valid4 = 1'b0;
        budget = 0;
        while (done4_n == 0 && budget < LAT + 20) begin @(posedge clk); budget++; end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out4_q.size() !== NP / 4) begin n_bad++; $display("FAIL lanes4 out_count got=%0d exp=%0d", out4_q.size(), NP / 4); end
        n_cmp++; if (done4_n !== 1) begin n_bad++; $display("FAIL lanes4 done_count got=%0d exp=1", done4_n); end
        for (int j = 0; j < out4_q.size() && j < NP / 4; j++) begin
            beat = out4_q[j];
            for (int l = 0; l < 4; l++) begin
                got = beat[l*32 +: 32];
                e = exp_pair(np, 4*j + l);
                n_cmp++;
                if (got !== e) begin n_bad++; $display("FAIL lanes4 pair[%0d] got=%h exp=%h", 4*j+l, got, e); end
            end
        end
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; in_valid = 1'b0; nacc = '0; a = '0; b = '0;
        start4 = 1'b0; in_valid4 = 1'b0; nacc4 = '0; a4 = '0; b4 = '0;
        for (int k = 0; k < NP; k++) zt[k] = modpow(17, 2 * brv7(k) + 1);

        test_reset();
        fill(0); drive_job("nacc1", 1, 0, 0, 1'b0);
        fill(0); drive_job("nacc0", 0, 0, 0, 1'b0);
        fill(0); drive_job("nacc3", 3, 0, 0, 1'b0);
        fill(1); drive_job("wrap_q", 2, 0, 0, 1'b0);
        fill(2); drive_job("rand_toggle", 4, 1, 0, 1'b0);
        fill(2); drive_job("rand_gaps", 3, 2, 0, 1'b0);
        fill(2); drive_job("abort", 2, 0, 60, 1'b0);
        drive_job("rerun", 2, 0, 0, 1'b0);
        fill(2); drive_job("extra_start", 3, 2, 0, 1'b1);
        test_lanes4(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
